// File: rtl/alu.sv
// Eight-bit accumulator ALU: A/B/ACC/INDEX registers, status flags and a
// one-cycle ACC-to-bus output strobe, executing one control-unit command per clock.
package global_pkg;
  typedef enum logic [4:0] {
    nop          = 5'd0,
    op_lda       = 5'd1,
    op_ldb       = 5'd2,
    op_ldacc     = 5'd3,
    op_ldid      = 5'd4,
    op_mvacc2id  = 5'd5,
    op_mvacc2a   = 5'd6,
    op_mvacc2b   = 5'd7,
    op_add       = 5'd8,
    op_sub       = 5'd9,
    op_shiftl    = 5'd10,
    op_shiftr    = 5'd11,
    op_and       = 5'd12,
    op_or        = 5'd13,
    op_xor       = 5'd14,
    op_cmpe      = 5'd15,
    op_cmpl      = 5'd16,
    op_cmpg      = 5'd17,
    op_ascii2bin = 5'd18,
    op_bin2ascii = 5'd19,
    op_oeacc     = 5'd20
  } alu_op;
endpackage

module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] alu_op_i,
  input  logic [7:0] inbus_i,
  output logic [7:0] outbus_o,
  output logic       oe_o,
  output logic [7:0] index_o,
  output logic       flag_z_o,
  output logic       flag_c_o,
  output logic       flag_n_o,
  output logic       flag_e_o
);
  import global_pkg::*;

  logic [7:0] a_q, a_d, b_q, b_d, acc_q, acc_d, idx_q, idx_d, out_q, out_d;
  logic       z_q, z_d, c_q, c_d, n_q, n_d, e_q, e_d, oe_q, oe_d;
  logic [8:0] sum;
  logic [4:0] nsum;
  alu_op      op;

  assign op   = alu_op'(alu_op_i);
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign nsum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    idx_d = idx_q;
    z_d   = z_q;
    c_d   = c_q;
    n_d   = n_q;
    e_d   = e_q;
    out_d = '0;
    oe_d  = 1'b0;
    unique case (op)
      op_lda:      a_d   = inbus_i;
      op_ldb:      b_d   = inbus_i;
      op_ldacc:    acc_d = inbus_i;
      op_ldid:     idx_d = inbus_i;
      op_mvacc2id: idx_d = acc_q;
      op_mvacc2a:  a_d   = acc_q;
      op_mvacc2b:  b_d   = acc_q;
      op_add: begin
        acc_d = sum[7:0];
        c_d   = sum[8];
        n_d   = nsum[4];
        z_d   = (sum[7:0] == 8'h00);
      end
      op_sub: begin
        acc_d = a_q - b_q;
        c_d   = (a_q < b_q);
        n_d   = (a_q[3:0] < b_q[3:0]);
        z_d   = (a_q == b_q);
      end
      op_shiftl: begin
        acc_d = {a_q[6:0], 1'b0};
        c_d   = a_q[7];
        z_d   = (a_q[6:0] == 7'h00);
      end
      op_shiftr: begin
        acc_d = {1'b0, a_q[7:1]};
        c_d   = a_q[0];
        z_d   = (a_q[7:1] == 7'h00);
      end
      op_and: begin
        acc_d = a_q & b_q;
        z_d   = ((a_q & b_q) == 8'h00);
      end
      op_or: begin
        acc_d = a_q | b_q;
        z_d   = ((a_q | b_q) == 8'h00);
      end
      op_xor: begin
        acc_d = a_q ^ b_q;
        z_d   = ((a_q ^ b_q) == 8'h00);
      end
      op_cmpe: z_d = (a_q == b_q);
      op_cmpl: z_d = (a_q < b_q);
      op_cmpg: z_d = (a_q > b_q);
      op_ascii2bin: begin
        if (a_q >= 8'h30 && a_q <= 8'h39) begin
          acc_d = a_q - 8'h30;
          e_d   = 1'b0;
          z_d   = (a_q == 8'h30);
        end else begin
          acc_d = 8'hFF;
          e_d   = 1'b1;
          z_d   = 1'b0;
        end
      end
      op_bin2ascii: begin
        // Result is either 0x30..0x39 or 0xFF, so Z can never be set here.
        if (a_q <= 8'h09) begin
          acc_d = a_q + 8'h30;
          e_d   = 1'b0;
        end else begin
          acc_d = 8'hFF;
          e_d   = 1'b1;
        end
        z_d = 1'b0;
      end
      op_oeacc: begin
        out_d = acc_q;
        oe_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      idx_q <= '0;
      out_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      n_q   <= 1'b0;
      e_q   <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      out_q <= out_d;
      z_q   <= z_d;
      c_q   <= c_d;
      n_q   <= n_d;
      e_q   <= e_d;
      oe_q  <= oe_d;
    end
  end

  assign outbus_o = out_q;
  assign oe_o     = oe_q;
  assign index_o  = idx_q;
  assign flag_z_o = z_q;
  assign flag_c_o = c_q;
  assign flag_n_o = n_q;
  assign flag_e_o = e_q;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: each record is one op plus the complete
// expected output state one edge later.
module tb_alu;
  import global_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] alu_op_i = 5'd0;
  logic [7:0] inbus_i = 8'h00;
  logic [7:0] outbus_o, index_o;
  logic       oe_o, flag_z_o, flag_c_o, flag_n_o, flag_e_o;

  int unsigned total = 0;
  int unsigned bad = 0;

  alu dut (
    .clk(clk), .rst_n(rst_n), .alu_op_i(alu_op_i), .inbus_i(inbus_i),
    .outbus_o(outbus_o), .oe_o(oe_o), .index_o(index_o),
    .flag_z_o(flag_z_o), .flag_c_o(flag_c_o), .flag_n_o(flag_n_o), .flag_e_o(flag_e_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [7:0] din;
    logic [7:0] out;
    logic       oe;
    logic [7:0] idx;
    logic       z, c, n, e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] op, input logic [7:0] din,
                              input logic [7:0] out, input logic oe, input logic [7:0] idx,
                              input logic z, input logic c, input logic n, input logic e);
    vec_t v;
    v.op = op; v.din = din; v.out = out; v.oe = oe; v.idx = idx;
    v.z = z; v.c = c; v.n = n; v.e = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] out, input logic oe,
                       input logic [7:0] idx, input logic z, input logic c,
                       input logic n, input logic e);
    logic [19:0] act, exp;
    act = {outbus_o, oe_o, index_o, flag_z_o, flag_c_o, flag_n_o, flag_e_o};
    exp = {out, oe, idx, z, c, n, e};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got out=%h oe=%b idx=%h zcne=%b%b%b%b, expected out=%h oe=%b idx=%h zcne=%b%b%b%b",
               name, outbus_o, oe_o, index_o, flag_z_o, flag_c_o, flag_n_o, flag_e_o,
               out, oe, idx, z, c, n, e);
    end
  endtask

  task automatic apply(input logic [4:0] op, input logic [7:0] din);
    @(negedge clk);
    alu_op_i = op;
    inbus_i  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // add: 0xF8+0x08
    vecs.push_back(mk(op_lda,   8'hF8, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(op_ldb,   8'h08, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(op_add,   8'h00, 8'h00, 0, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(op_oeacc, 8'h00, 8'h00, 1, 8'h00, 1, 1, 1, 0));
    // add: 0x12+0x34
    vecs.push_back(mk(op_lda,   8'h12, 8'h00, 0, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(op_ldb,   8'h34, 8'h00, 0, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(op_add,   8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(op_oeacc, 8'h00, 8'h46, 1, 8'h00, 0, 0, 0, 0));
    // sub: 0x10-0x01
    vecs.push_back(mk(op_lda,   8'h10, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(op_ldb,   8'h01, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(op_sub,   8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(op_oeacc, 8'h00, 8'h0F, 1, 8'h00, 0, 0, 1, 0));
    // shifts of 0x81
    vecs.push_back(mk(op_lda,    8'h81, 8'h00, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(op_shiftl, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_oeacc,  8'h00, 8'h02, 1, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_shiftr, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_oeacc,  8'h00, 8'h40, 1, 8'h00, 0, 1, 1, 0));
    // compares 5 vs 9, then 0x7E == 0x7E
    vecs.push_back(mk(op_lda,   8'h05, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_ldb,   8'h09, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_cmpl,  8'h00, 8'h00, 0, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(op_cmpg,  8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_cmpe,  8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_oeacc, 8'h00, 8'h40, 1, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_lda,   8'h7E, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_ldb,   8'h7E, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_cmpe,  8'h00, 8'h00, 0, 8'h00, 1, 1, 1, 0));
    // conversions
    vecs.push_back(mk(op_lda,       8'h37, 8'h00, 0, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(op_ascii2bin, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_oeacc,     8'h00, 8'h07, 1, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_lda,       8'h41, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_ascii2bin, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(op_oeacc,     8'h00, 8'hFF, 1, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(op_and,       8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(op_oeacc,     8'h00, 8'h40, 1, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(op_lda,       8'h09, 8'h00, 0, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(op_bin2ascii, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_oeacc,     8'h00, 8'h39, 1, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_lda,       8'h0A, 8'h00, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(op_bin2ascii, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(op_oeacc,     8'h00, 8'hFF, 1, 8'h00, 0, 1, 1, 1));
    // moves, illegal encoding, back-to-back output
    vecs.push_back(mk(op_ldacc,    8'h5A, 8'h00, 0, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(op_mvacc2id, 8'h00, 8'h00, 0, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(5'd31,       8'hC3, 8'h00, 0, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(op_oeacc,    8'h00, 8'h5A, 1, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(op_oeacc,    8'h00, 8'h5A, 1, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(nop,         8'h00, 8'h00, 0, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(op_mvacc2a,  8'h00, 8'h00, 0, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(op_mvacc2b,  8'h00, 8'h00, 0, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(op_xor,      8'h00, 8'h00, 0, 8'h5A, 1, 1, 1, 1));
    vecs.push_back(mk(op_oeacc,    8'h00, 8'h00, 1, 8'h5A, 1, 1, 1, 1));
    vecs.push_back(mk(op_or,       8'h00, 8'h00, 0, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(op_oeacc,    8'h00, 8'h5A, 1, 8'h5A, 0, 1, 1, 1));
    vecs.push_back(mk(op_ldid,     8'h33, 8'h00, 0, 8'h33, 0, 1, 1, 1));
    vecs.push_back(mk(op_sub,      8'h00, 8'h00, 0, 8'h33, 1, 0, 0, 1));
    vecs.push_back(mk(op_oeacc,    8'h00, 8'h00, 1, 8'h33, 1, 0, 0, 1));

    #12;
    check("reset_state", 8'h00, 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].op, vecs[i].din);
      check($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].out, vecs[i].oe,
            vecs[i].idx, vecs[i].z, vecs[i].c, vecs[i].n, vecs[i].e);
    end

    // Asynchronous reset between edges while oe and flags are set.
    apply(op_ldacc, 8'hA5);
    apply(op_oeacc, 8'h00);
    check("pre_reset_oe", 8'hA5, 1, 8'h33, 1, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'h00, 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(op_oeacc, 8'h00);
    check("post_reset_oeacc", 8'h00, 1, 8'h00, 0, 0, 0, 0);
    apply(nop, 8'h00);
    check("post_reset_nop", 8'h00, 0, 8'h00, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
